// File: rtl/block_dispatch_pkg.sv
// block_dispatch_pkg: shared types and default configuration for block_dispatcher.
//   dispatch_mode_t : scheduling mode selected by the run-time `mode` input
//   DEFAULT_*       : default values for the dispatcher parameters
//   lane_entry_t    : layout of one lane FIFO entry in the default configuration
//                     (the top declares the same layout at its own widths)
package block_dispatch_pkg;

    typedef enum logic {
        DISPATCH_RR        = 1'b0,
        DISPATCH_LEAST_OCC = 1'b1
    } dispatch_mode_t;

    localparam int DEFAULT_BLOCK_WIDTH       = 32;
    localparam int DEFAULT_NUM_LANES         = 4;
    localparam int DEFAULT_SEQUENCE_ID_WIDTH = 8;
    localparam int DEFAULT_LANE_FIFO_DEPTH   = 4;

    typedef struct packed {
        logic [DEFAULT_SEQUENCE_ID_WIDTH-1:0] seq_id;
        logic [DEFAULT_BLOCK_WIDTH-1:0]       data;
    } lane_entry_t;

endpackage

// File: rtl/block_dispatcher_if.sv
// block_dispatcher_if: input stream plus per-lane output streams of the dispatcher.
//   data_in / data_in_valid / data_in_ready : single input block stream
//   lane_data / lane_seq_id / lane_valid    : per-lane head-of-FIFO outputs
//   lane_ready                              : per-lane consumer ready
// Modports: master = producer/consumer side (testbench, framer, lanes),
//           slave  = the dispatcher.
//
// Handshake: every stream transfers exactly on a rising edge where valid and
// ready are both high; valid never depends on ready, and data is held stable
// by the sender while valid is high and ready is low.
interface block_dispatcher_if
    import block_dispatch_pkg::*;
#(
    parameter int BLOCK_WIDTH       = DEFAULT_BLOCK_WIDTH,
    parameter int NUM_LANES         = DEFAULT_NUM_LANES,
    parameter int SEQUENCE_ID_WIDTH = DEFAULT_SEQUENCE_ID_WIDTH
);
    logic [BLOCK_WIDTH-1:0]                          data_in;
    logic                                            data_in_valid;
    logic                                            data_in_ready;
    logic [NUM_LANES-1:0][BLOCK_WIDTH-1:0]           lane_data;
    logic [NUM_LANES-1:0][SEQUENCE_ID_WIDTH-1:0]     lane_seq_id;
    logic [NUM_LANES-1:0]                            lane_valid;
    logic [NUM_LANES-1:0]                            lane_ready;

    modport master (
        output data_in, data_in_valid, lane_ready,
        input  data_in_ready, lane_data, lane_seq_id, lane_valid
    );

    modport slave (
        input  data_in, data_in_valid, lane_ready,
        output data_in_ready, lane_data, lane_seq_id, lane_valid
    );
endinterface

// File: rtl/lane_fifo.sv
// lane_fifo: synchronous FIFO holding one lane's pending entries.
//   clock, reset (sync, active-low)
//   push, push_data : write an entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry, read straight from the storage registers
//   full, empty, occupancy : fill status after the most recent edge
// Push and pop in the same cycle are both honoured when the FIFO is not full.
module lane_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is cleared on reset so the head reads zero until the first write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign full      = (count == OCC_W'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;
endmodule

// File: rtl/block_dispatcher.sv
// block_dispatcher: tags each accepted input block with a wrapping sequence ID
// and buffers it in one of NUM_LANES per-lane FIFOs.
//   clock, reset (sync, active-low)
//   mode            : 0 = strict round-robin, 1 = least-occupied lane
//   bus (slave)     : input stream and per-lane output streams
//   lane_occupancy  : entries held per lane
//   seq_next        : tag the next accepted block will carry
//   busy            : any lane non-empty
//   stat_accepted   : accepted-block counter
//   stat_stall      : cycles with data_in_valid high and data_in_ready low
// Optional feature: define BLOCK_DISPATCHER_STATS_EN to build the saturating
// statistics counters; otherwise both stat ports read zero.
module block_dispatcher
    import block_dispatch_pkg::*;
#(
    parameter int BLOCK_WIDTH       = DEFAULT_BLOCK_WIDTH,
    parameter int NUM_LANES         = DEFAULT_NUM_LANES,
    parameter int SEQUENCE_ID_WIDTH = DEFAULT_SEQUENCE_ID_WIDTH,
    parameter int LANE_FIFO_DEPTH   = DEFAULT_LANE_FIFO_DEPTH,
    localparam int OCC_W            = $clog2(LANE_FIFO_DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                mode,
    block_dispatcher_if.slave                   bus,
    output logic [NUM_LANES-1:0][OCC_W-1:0]     lane_occupancy,
    output logic [SEQUENCE_ID_WIDTH-1:0]        seq_next,
    output logic                                busy,
    output logic [31:0]                         stat_accepted,
    output logic [31:0]                         stat_stall
);
    localparam int LANE_W = $clog2(NUM_LANES);

    typedef struct packed {
        logic [SEQUENCE_ID_WIDTH-1:0] seq_id;
        logic [BLOCK_WIDTH-1:0]       data;
    } entry_t;

    dispatch_mode_t       mode_sel;
    logic [LANE_W-1:0]    rr_ptr;
    logic [LANE_W-1:0]    least_idx;
    logic [OCC_W-1:0]     least_occ;
    logic [LANE_W-1:0]    target;
    logic                 in_ready;
    logic                 accept;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_empty;
    logic [NUM_LANES-1:0] lane_push;
    entry_t               push_entry;
    entry_t               lane_head [NUM_LANES];

    assign mode_sel = dispatch_mode_t'(mode);

    // Lowest occupancy wins; strict '<' keeps ties on the lowest index.
    always_comb begin
        least_idx = '0;
        least_occ = lane_occupancy[0];
        for (int i = 1; i < NUM_LANES; i++) begin
            if (lane_occupancy[i] < least_occ) begin
                least_idx = LANE_W'(i);
                least_occ = lane_occupancy[i];
            end
        end
    end

    // Ready is built only from registered fill state, never from lane_ready,
    // so a pop on a full lane frees it one cycle later.
    always_comb begin
        target   = rr_ptr;
        in_ready = 1'b0;
        if (mode_sel == DISPATCH_RR) begin
            target   = rr_ptr;
            in_ready = !lane_full[rr_ptr];
        end else begin
            target   = least_idx;
            in_ready = !(&lane_full);
        end
    end

    assign bus.data_in_ready = in_ready;
    assign accept            = bus.data_in_valid && in_ready;
    assign push_entry        = '{seq_id: seq_next, data: bus.data_in};

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr   <= '0;
            seq_next <= '0;
        end else if (accept) begin
            seq_next <= seq_next + SEQUENCE_ID_WIDTH'(1);
            // The round-robin pointer only moves on a round-robin acceptance.
            if (mode_sel == DISPATCH_RR) begin
                rr_ptr <= (rr_ptr == LANE_W'(NUM_LANES - 1)) ? '0 : rr_ptr + LANE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_push[i] = accept && (target == LANE_W'(i));

        lane_fifo #(
            .WIDTH($bits(entry_t)),
            .DEPTH(LANE_FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (lane_push[i]),
            .push_data (push_entry),
            .pop       (bus.lane_ready[i] && !lane_empty[i]),
            .head      (lane_head[i]),
            .full      (lane_full[i]),
            .empty     (lane_empty[i]),
            .occupancy (lane_occupancy[i])
        );

        assign bus.lane_data[i]   = lane_head[i].data;
        assign bus.lane_seq_id[i] = lane_head[i].seq_id;
        assign bus.lane_valid[i]  = !lane_empty[i];
    end

    assign busy = !(&lane_empty);

`ifdef BLOCK_DISPATCHER_STATS_EN
    logic [31:0] accepted_q;
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            accepted_q <= '0;
            stall_q    <= '0;
        end else begin
            if (accept && (accepted_q != '1)) begin
                accepted_q <= accepted_q + 32'd1;
            end
            if (bus.data_in_valid && !in_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_accepted = accepted_q;
    assign stat_stall    = stall_q;
`else
    assign stat_accepted = '0;
    assign stat_stall    = '0;
`endif
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: directed self-checking bench for block_dispatcher.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
module tb_block_dispatcher;
    import block_dispatch_pkg::*;

    localparam int BW    = 32;
    localparam int NL    = 4;
    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int OCC_W = 3;
    localparam int LB    = 2;
    localparam int REC_W = LB + SW + BW;

`ifdef BLOCK_DISPATCHER_STATS_EN
    localparam logic [31:0] EXP_ACC_A = 32'd10;
    localparam logic [31:0] EXP_ACC_B = 32'd16;
    localparam logic [31:0] EXP_STALL = 32'd3;
`else
    localparam logic [31:0] EXP_ACC_A = 32'd0;
    localparam logic [31:0] EXP_ACC_B = 32'd0;
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic mode  = 1'b0;
    logic [NL-1:0][OCC_W-1:0] lane_occupancy;
    logic [SW-1:0]            seq_next;
    logic                     busy;
    logic [31:0]              stat_accepted;
    logic [31:0]              stat_stall;

    block_dispatcher_if #(.BLOCK_WIDTH(BW), .NUM_LANES(NL), .SEQUENCE_ID_WIDTH(SW)) bus ();

    block_dispatcher #(
        .BLOCK_WIDTH(BW), .NUM_LANES(NL), .SEQUENCE_ID_WIDTH(SW), .LANE_FIFO_DEPTH(DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mode           (mode),
        .bus            (bus),
        .lane_occupancy (lane_occupancy),
        .seq_next       (seq_next),
        .busy           (busy),
        .stat_accepted  (stat_accepted),
        .stat_stall     (stat_stall)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- scoreboard: pop monitor ----------------
    // Record = {lane, seq_id, data} of every block that leaves a lane.
    logic [REC_W-1:0] mon_q[$];
    logic [REC_W-1:0] exp_q[$];

    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                if (bus.lane_valid[i] && bus.lane_ready[i]) begin
                    mon_q.push_back({LB'(i), bus.lane_seq_id[i], bus.lane_data[i]});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b0;
        mode              = 1'b0;
        bus.data_in_valid = 1'b0;
        bus.data_in       = '0;
        bus.lane_ready    = '0;
        step();
        step();
        reset = 1'b1;
        mon_q.delete();
        exp_q.delete();
    endtask

    // Offers one block and returns just after the edge that accepted it,
    // leaving data_in_valid high so consecutive calls run back to back.
    task automatic push(input logic [BW-1:0] d);
        bit ok;
        ok                = 1'b0;
        bus.data_in       = d;
        bus.data_in_valid = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clock);
            ok = bus.data_in_ready;
            step();
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: block %h got data_in_ready=%b, required 1", d, bus.data_in_ready);
        end
    endtask

    task automatic idle();
        bus.data_in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clock);
        n_vec++; if (bus.data_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", bus.data_in_ready); end
        n_vec++; if (bus.lane_valid !== 4'b0000) begin n_err++; $display("FAIL reset_lane_valid: got %b, required 0000", bus.lane_valid); end
        n_vec++; if (bus.lane_data !== '0) begin n_err++; $display("FAIL reset_lane_data: got %h, required 0", bus.lane_data); end
        n_vec++; if (bus.lane_seq_id !== '0) begin n_err++; $display("FAIL reset_lane_seq: got %h, required 0", bus.lane_seq_id); end
        n_vec++; if (lane_occupancy !== '0) begin n_err++; $display("FAIL reset_occupancy: got %h, required 0", lane_occupancy); end
        n_vec++; if (seq_next !== 8'd0) begin n_err++; $display("FAIL reset_seq_next: got %0d, required 0", seq_next); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_vec++; if (stat_accepted !== 32'd0) begin n_err++; $display("FAIL reset_stat_accepted: got %0d, required 0", stat_accepted); end
        n_vec++; if (stat_stall !== 32'd0) begin n_err++; $display("FAIL reset_stat_stall: got %0d, required 0", stat_stall); end
        step();
    endtask

    task automatic test_rr_distribution();
        do_reset();
        mode           = 1'b0;
        bus.lane_ready = '1;
        push(32'hA000_0000);
        idle();
        @(negedge clock);
        n_vec++; if (bus.lane_valid[0] !== 1'b1) begin n_err++; $display("FAIL rr_latency_valid: got %b, required 1", bus.lane_valid[0]); end
        n_vec++; if (bus.lane_data[0] !== 32'hA000_0000) begin n_err++; $display("FAIL rr_latency_data: got %h, required a0000000", bus.lane_data[0]); end
        n_vec++; if (bus.lane_valid[3:1] !== 3'b000) begin n_err++; $display("FAIL rr_other_lanes: got %b, required 000", bus.lane_valid[3:1]); end
        step();
        for (int k = 1; k < 8; k++) begin
            push(32'hA000_0000 + 32'(k));
        end
        idle();
        repeat (4) step();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({LB'(k % 4), SW'(k), 32'hA000_0000 + 32'(k)});
        end
        n_vec++;
        if (mon_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rr_pop_count: got %0d, required %0d", mon_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_vec++;
                if (mon_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rr_pop[%0d]: got %h, required %h", k, mon_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_rr_backpressure();
        logic [REC_W-1:0] got_q[$];
        do_reset();
        mode           = 1'b0;
        bus.lane_ready = 4'b1101;
        for (int k = 0; k < 17; k++) begin
            push(32'hB000_0000 + 32'(k));
        end
        bus.data_in = 32'hB000_0011;
        @(negedge clock);
        n_vec++; if (bus.data_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready: got %b, required 0", bus.data_in_ready); end
        n_vec++; if (lane_occupancy[1] !== 3'd4) begin n_err++; $display("FAIL bp_lane1_full: got %0d, required 4", lane_occupancy[1]); end
        n_vec++; if (seq_next !== 8'd17) begin n_err++; $display("FAIL bp_seq_next: got %0d, required 17", seq_next); end
        step();
        bus.lane_ready = 4'b1111;
        @(negedge clock);
        n_vec++; if (bus.data_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_comb_path: got %b, required 0", bus.data_in_ready); end
        step();
        @(negedge clock);
        n_vec++; if (bus.data_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise: got %b, required 1", bus.data_in_ready); end
        n_vec++; if (lane_occupancy[1] !== 3'd3) begin n_err++; $display("FAIL bp_after_pop: got %0d, required 3", lane_occupancy[1]); end
        step();
        idle();
        n_vec++; if (lane_occupancy[1] !== 3'd3) begin n_err++; $display("FAIL bp_push_pop_same_lane: got %0d, required 3", lane_occupancy[1]); end
        n_vec++; if (seq_next !== 8'd18) begin n_err++; $display("FAIL bp_seq_after: got %0d, required 18", seq_next); end
        repeat (6) step();
        for (int k = 1; k < 18; k += 4) begin
            exp_q.push_back({LB'(1), SW'(k), 32'hB000_0000 + 32'(k)});
        end
        for (int k = 0; k < mon_q.size(); k++) begin
            if (mon_q[k][REC_W-1 -: LB] == LB'(1)) got_q.push_back(mon_q[k]);
        end
        n_vec++; if (mon_q.size() != 18) begin n_err++; $display("FAIL bp_total_pops: got %0d, required 18", mon_q.size()); end
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL bp_lane1_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_vec++;
                if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_lane1_pop[%0d]: got %h, required %h", k, got_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_least_occupied();
        do_reset();
        mode           = 1'b1;
        bus.lane_ready = '0;
        for (int k = 0; k < 4; k++) begin
            push(32'hC000_0000 + 32'(k));
        end
        idle();
        for (int i = 0; i < NL; i++) begin
            n_vec++; if (lane_occupancy[i] !== 3'd1) begin n_err++; $display("FAIL lo_spread_occ[%0d]: got %0d, required 1", i, lane_occupancy[i]); end
            n_vec++; if (bus.lane_data[i] !== 32'hC000_0000 + 32'(i)) begin n_err++; $display("FAIL lo_spread_data[%0d]: got %h, required %h", i, bus.lane_data[i], 32'hC000_0000 + 32'(i)); end
            n_vec++; if (bus.lane_seq_id[i] !== SW'(i)) begin n_err++; $display("FAIL lo_spread_seq[%0d]: got %0d, required %0d", i, bus.lane_seq_id[i], i); end
        end
        bus.lane_ready = 4'b0100;
        step();
        bus.lane_ready = '0;
        n_vec++; if (lane_occupancy[2] !== 3'd0) begin n_err++; $display("FAIL lo_drain: got %0d, required 0", lane_occupancy[2]); end
        push(32'hC000_0004);
        idle();
        n_vec++; if (bus.lane_data[2] !== 32'hC000_0004) begin n_err++; $display("FAIL lo_refill_data: got %h, required c0000004", bus.lane_data[2]); end
        n_vec++; if (bus.lane_seq_id[2] !== 8'd4) begin n_err++; $display("FAIL lo_refill_seq: got %0d, required 4", bus.lane_seq_id[2]); end
        n_vec++; if (lane_occupancy !== {3'd1, 3'd1, 3'd1, 3'd1}) begin n_err++; $display("FAIL lo_refill_occ: got %h, required 249", lane_occupancy); end
        // Round-robin pointer was held at 0 throughout least-occupied mode.
        mode = 1'b0;
        push(32'hC000_0005);
        idle();
        n_vec++; if (lane_occupancy !== {3'd1, 3'd1, 3'd1, 3'd2}) begin n_err++; $display("FAIL lo_rr_held: got %h, required 24a", lane_occupancy); end
        mode = 1'b1;
        for (int k = 6; k < 17; k++) begin
            push(32'hC000_0000 + 32'(k));
        end
        idle();
        n_vec++; if (lane_occupancy !== {3'd4, 3'd4, 3'd4, 3'd4}) begin n_err++; $display("FAIL lo_all_full_occ: got %h, required 924", lane_occupancy); end
        n_vec++; if (bus.data_in_ready !== 1'b0) begin n_err++; $display("FAIL lo_all_full_ready: got %b, required 0", bus.data_in_ready); end
        mode = 1'b0;
        #1;
        n_vec++; if (bus.data_in_ready !== 1'b0) begin n_err++; $display("FAIL lo_rr_full_ready: got %b, required 0", bus.data_in_ready); end
        step();
    endtask

    task automatic test_seq_wrap();
        logic [REC_W-1:0] e;
        do_reset();
        mode           = 1'b0;
        bus.lane_ready = '1;
        for (int k = 0; k < 300; k++) begin
            push(32'hD000_0000 + 32'(k));
        end
        idle();
        repeat (4) step();
        n_vec++;
        if (mon_q.size() != 300) begin
            n_err++; $display("FAIL wrap_count: got %0d, required 300", mon_q.size());
        end else begin
            e = {2'd3, 8'd255, 32'hD000_00FF};
            n_vec++; if (mon_q[255] !== e) begin n_err++; $display("FAIL wrap_blk255: got %h, required %h", mon_q[255], e); end
            e = {2'd0, 8'd0, 32'hD000_0100};
            n_vec++; if (mon_q[256] !== e) begin n_err++; $display("FAIL wrap_blk256: got %h, required %h", mon_q[256], e); end
            e = {2'd3, 8'd43, 32'hD000_012B};
            n_vec++; if (mon_q[299] !== e) begin n_err++; $display("FAIL wrap_blk299: got %h, required %h", mon_q[299], e); end
        end
        n_vec++; if (seq_next !== 8'd44) begin n_err++; $display("FAIL wrap_seq_next: got %0d, required 44", seq_next); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode           = 1'b0;
        bus.lane_ready = '0;
        for (int k = 0; k < 9; k++) begin
            push(32'hE000_0000 + 32'(k));
        end
        idle();
        n_vec++; if (lane_occupancy[0] !== 3'd3) begin n_err++; $display("FAIL rst_mid_pre_occ: got %0d, required 3", lane_occupancy[0]); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_busy: got %b, required 1", busy); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_vec++; if (bus.lane_valid !== 4'b0000) begin n_err++; $display("FAIL rst_mid_valid: got %b, required 0000", bus.lane_valid); end
        n_vec++; if (lane_occupancy !== '0) begin n_err++; $display("FAIL rst_mid_occ: got %h, required 0", lane_occupancy); end
        n_vec++; if (seq_next !== 8'd0) begin n_err++; $display("FAIL rst_mid_seq_next: got %0d, required 0", seq_next); end
        n_vec++; if (bus.data_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b, required 1", bus.data_in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
        n_vec++; if (bus.lane_data !== '0) begin n_err++; $display("FAIL rst_mid_data: got %h, required 0", bus.lane_data); end
        bus.lane_ready = '1;
        repeat (3) step();
        n_vec++; if (mon_q.size() != 0) begin n_err++; $display("FAIL rst_mid_discard: got %0d pops, required 0", mon_q.size()); end
        push(32'hE000_0009);
        idle();
        n_vec++; if (bus.lane_valid !== 4'b0001) begin n_err++; $display("FAIL rst_mid_rr_restart: got %b, required 0001", bus.lane_valid); end
        n_vec++; if (bus.lane_seq_id[0] !== 8'd0) begin n_err++; $display("FAIL rst_mid_first_seq: got %0d, required 0", bus.lane_seq_id[0]); end
        step();
    endtask

    task automatic test_stats();
        do_reset();
        mode           = 1'b0;
        bus.lane_ready = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            push(32'hF000_0000 + 32'(k));
        end
        idle();
        n_vec++; if (stat_accepted !== EXP_ACC_A) begin n_err++; $display("FAIL stats_acc_10: got %0d, required %0d", stat_accepted, EXP_ACC_A); end
        n_vec++; if (stat_stall !== 32'd0) begin n_err++; $display("FAIL stats_stall_0: got %0d, required 0", stat_stall); end
        for (int k = 10; k < 16; k++) begin
            push(32'hF000_0000 + 32'(k));
        end
        // Lane 0 now holds blocks 0, 4, 8, 12 and is the round-robin target.
        repeat (3) step();
        idle();
        n_vec++; if (bus.data_in_ready !== 1'b0) begin n_err++; $display("FAIL stats_stalled_ready: got %b, required 0", bus.data_in_ready); end
        n_vec++; if (stat_accepted !== EXP_ACC_B) begin n_err++; $display("FAIL stats_acc_16: got %0d, required %0d", stat_accepted, EXP_ACC_B); end
        n_vec++; if (stat_stall !== EXP_STALL) begin n_err++; $display("FAIL stats_stall_3: got %0d, required %0d", stat_stall, EXP_STALL); end
        repeat (2) step();
        n_vec++; if (stat_stall !== EXP_STALL) begin n_err++; $display("FAIL stats_stall_idle: got %0d, required %0d", stat_stall, EXP_STALL); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        bus.lane_ready    = '0;
        test_reset();
        test_rr_distribution();
        test_rr_backpressure();
        test_least_occupied();
        test_seq_wrap();
        test_reset_mid();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
